// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the SRAM data-memory controller: FSM states,
// the data segment base and the idle level of the SRAM strobes.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_LO = 3'd1,
        ST_RD_HI = 3'd2,
        ST_WR_LO = 3'd3,
        ST_WR_HI = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Word index of the start of the data segment (ALU_Res >> 2).
    localparam int BASE_WORD_DEF = 1024;

    // SRAM strobes are active low; this is their deasserted level.
    localparam logic STROBE_IDLE = 1'b1;

endpackage

// File: rtl/sram_phase_counter.sv
// Times one SRAM halfword phase: cleared on phase entry, raises `last`
// on the WAIT_CYCLES-th cycle spent in the phase.
module sram_phase_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic last
);

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Clear on entry into a phase, otherwise count cycles in the phase.
    always_comb begin
        cnt_d = cnt_q + 4'd1;
        if (load) begin
            cnt_d = 4'd0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == LAST_CNT);

endmodule

// File: rtl/sram_mem_controller.sv
// MEM-stage data memory front end: turns a 32-bit word read/write into two
// 16-bit external SRAM accesses (low halfword first) and holds `ready` low
// until the word transfer is finished.
//
// Handshake: a request (MEM_R_EN or MEM_W_EN) is taken in IDLE and must be
// held stable while ready=0; ready=1 in DONE marks completion, and whatever
// request is present in the following cycle starts a fresh access.
module sram_mem_controller
    import mem_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_WORD   = BASE_WORD_DEF,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        ALU_Res,
    input  logic [31:0]        Val_Rm,
    output logic [31:0]        DM_out,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n
);

    state_e      state_q;
    state_e      state_d;
    logic [31:0] dm_q;
    logic [31:0] dm_d;
    logic        phase_last;
    logic        phase_load;
    logic        in_phase;
    logic [31:0] word;
    logic        unused_word_bits;

    // Word offset into the SRAM; high bits beyond the SRAM size wrap away.
    assign word             = (ALU_Res >> 2) - 32'(BASE_WORD);
    assign unused_word_bits = ^word[31:SRAM_AW-1];

    assign in_phase = (state_q == ST_RD_LO) || (state_q == ST_RD_HI) ||
                      (state_q == ST_WR_LO) || (state_q == ST_WR_HI);

    // Restart the phase timer whenever the state changes or no phase is active.
    assign phase_load = (state_d != state_q) || !in_phase;

    sram_phase_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_phase_counter (
        .clk (clk),
        .rst (rst),
        .load(phase_load),
        .last(phase_last)
    );

    // Next-state logic: write wins over read, each halfword phase ends on `last`.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (MEM_W_EN) begin
                    state_d = ST_WR_LO;
                end else if (MEM_R_EN) begin
                    state_d = ST_RD_LO;
                end
            end
            ST_RD_LO: if (phase_last) state_d = ST_RD_HI;
            ST_RD_HI: if (phase_last) state_d = ST_DONE;
            ST_WR_LO: if (phase_last) state_d = ST_WR_HI;
            ST_WR_HI: if (phase_last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // SRAM strobes, bus drive, ready and read-data capture per state.
    always_comb begin
        sram_ce_n   = STROBE_IDLE;
        sram_oe_n   = STROBE_IDLE;
        sram_we_n   = STROBE_IDLE;
        sram_dq_oe  = 1'b0;
        sram_addr   = '0;
        sram_dq_out = 16'h0000;
        ready       = 1'b0;
        dm_d        = dm_q;
        case (state_q)
            ST_IDLE: begin
                ready = !MEM_R_EN && !MEM_W_EN;
            end
            ST_RD_LO, ST_RD_HI: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                sram_addr = {word[SRAM_AW-2:0], (state_q == ST_RD_HI)};
                if (phase_last) begin
                    if (state_q == ST_RD_LO) begin
                        dm_d[15:0] = sram_dq_in;
                    end else begin
                        dm_d[31:16] = sram_dq_in;
                    end
                end
            end
            ST_WR_LO, ST_WR_HI: begin
                sram_ce_n   = 1'b0;
                sram_we_n   = 1'b0;
                sram_dq_oe  = 1'b1;
                sram_addr   = {word[SRAM_AW-2:0], (state_q == ST_WR_HI)};
                sram_dq_out = (state_q == ST_WR_LO) ? Val_Rm[15:0] : Val_Rm[31:16];
            end
            ST_DONE: begin
                ready = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    // State and read-data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dm_q    <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            dm_q    <= dm_d;
        end
    end

    assign DM_out = dm_q;

endmodule
